uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; consumes the serial line driven by the team's UART transmitter (TX_OUT to RX_IN in loopback or over a link).
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Runs on a clock OVERSAMPLE times the transmitter bit rate.
- Recovers each byte with a 3-sample majority vote near mid-bit and reports it as a one-cycle pulse with parity and framing status.

Parameters:
- OVERSAMPLE, 8, clock cycles per serial bit; even, minimum 4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- CLK  input  1  receiver clock (OVERSAMPLE x bit rate)
- RST  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line; idle high
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATA_WIDTH  last correctly received byte
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated
- PAR_ERR  output  1  one-cycle pulse, parity mismatch
- STP_ERR  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- One clock domain: CLK. RST is asynchronous and active-high.
- Reset:
  - state = IDLE; all counters 0; P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR = 0; armed = 0.
  - Reset mid-frame abandons the frame; no output pulse is produced.
- Line sample (rx_s):
  - RX_IN directly, or the synchronizer output (see Optional Feature).
- Arming:
  - IDLE accepts a start edge only when armed = 1.
  - armed is set by any cycle with rx_s = 1 in IDLE.
  - armed is cleared by reset and on entry to IDLE after an STP_ERR.
  - Effect: a held-low line (break) does not produce repeated frames.
- Counters:
  - edge_cnt counts 0..OVERSAMPLE-1 within a bit and wraps at OVERSAMPLE-1.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling:
  - rx_s is captured at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The majority value is formed at edge_cnt = OVERSAMPLE/2+1 (the "decision tick").
- State machine:
  - IDLE: when armed and rx_s = 0, go to START. That cycle is edge_cnt 0 of the start bit. PAR_EN and PAR_TYP are latched here; changes mid-frame are ignored.
  - START: at the decision tick, majority = 1 means a glitch; return to IDLE with no pulse (armed stays 1). Otherwise, at the edge_cnt wrap, go to DATA.
  - DATA: at each decision tick, the majority is shifted into the shift register MSB-side, giving LSB-first assembly. At the wrap with bit_cnt = DATA_WIDTH-1, go to PARITY if PAR_EN was latched, else STOP.
  - PARITY:
    - At the decision tick, compare the majority with the expected bit.
    - Expected bit: XOR of the data for even parity, inverted for odd.
    - The mismatch flag is held; at the wrap, go to STOP.
  - STOP:
    - At the decision tick, evaluate and go to IDLE immediately (half a bit early, so the next start edge can be caught).
    - stop = 1 and no parity mismatch: next cycle P_DATA <= shift register, DATA_VALID = 1.
    - stop = 1 and parity mismatch: next cycle PAR_ERR = 1; P_DATA unchanged.
    - stop = 0: next cycle STP_ERR = 1 (PAR_ERR also 1 if mismatched); P_DATA unchanged; armed cleared.
- Latency:
  - Let cycle 0 be the first low sample in IDLE. The output pulse occurs at cycle (1 + DATA_WIDTH + PAR_EN)·OVERSAMPLE + OVERSAMPLE/2 + 2.
  - OVERSAMPLE = 8, no parity: cycle 78. With parity: cycle 86.
- Back-to-back frames:
  - A start bit immediately following a stop bit is detected with no lost frame.
  - The output pulse and the new start edge may occur in the same cycle; both are handled.
- All outputs are registered. The pulses are never asserted in two consecutive cycles.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a two-flop synchronizer, reset to 1, before use. All latencies grow by 2 cycles (OVERSAMPLE = 8, no parity: pulse at cycle 80 relative to RX_IN falling).
- Undefined: RX_IN is used directly. This is legal only when RX_IN is generated in the CLK domain (e.g. loopback).

Test Plan:
- OVERSAMPLE = 8, PAR_EN = 0, frame 0xA5 -> DATA_VALID pulse at cycle 78, P_DATA = 0xA5, PAR_ERR = STP_ERR = 0.
- PAR_EN = 1, PAR_TYP = 0, 0x3C with parity bit 0 -> DATA_VALID at cycle 86, P_DATA = 0x3C; repeat with parity bit 1 -> PAR_ERR pulse, P_DATA stays 0x3C.
- PAR_EN = 1, PAR_TYP = 1, 0x01 with parity bit 0 -> valid; then 0x55 with stop bit forced 0 and line held low 40 cycles -> one STP_ERR pulse, no further frames until the line returns high.
- RX_IN low for 3 cycles only, in IDLE -> FSM returns to IDLE, no output pulses; a following valid 0x0F frame is received.
- Two frames, 0xFF then 0x00, with no idle gap -> two DATA_VALID pulses spaced 80 cycles apart, correct data.
- Assert RST at cycle 40 of a frame, release, send 0x81 -> no pulse from the aborted frame; 0x81 received; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 3-sample mid-bit majority vote and parity/framing status.
// Define UART_RX_SYNC_EN to pass RX_IN through a two-flop synchronizer (adds 2 cycles of latency).
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);
    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] E_S0   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] E_S1   = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] E_DEC  = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rx_s;
`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK or posedge RST)
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    state_t                state_q, state_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  mis_q, mis_d, armed_q, armed_d;
    logic                  valid_q, valid_d, perr_q, perr_d, serr_q, serr_d;
    logic                  maj, wrap, dec;

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        mis_d     = mis_q;
        armed_d   = armed_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        maj       = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
        wrap      = edge_q == E_LAST;
        dec       = edge_q == E_DEC;
        if (state_q != IDLE) begin
            edge_d = wrap ? '0 : edge_q + EW'(1);
            if (edge_q == E_S0) samp_d[0] = rx_s;
            if (edge_q == E_S1) samp_d[1] = rx_s;
        end
        case (state_q)
            IDLE: begin
                if (rx_s) armed_d = 1'b1;
                else if (armed_q) begin
                    // the detecting cycle itself is edge 0 of the start bit
                    state_d   = START;
                    edge_d    = EW'(1);
                    bit_d     = '0;
                    mis_d     = 1'b0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                if (dec && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (wrap) state_d = DATA;
            end
            DATA: begin
                if (dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (wrap) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == B_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (dec) mis_d = maj != (^shift_q ^ par_typ_q);
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // leave half a bit early so an immediately following start edge is caught
                if (dec) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    valid_d = maj & ~mis_q;
                    perr_d  = mis_q;
                    serr_d  = ~maj;
                    armed_d = maj;
                    data_d  = (maj & ~mis_q) ? shift_q : data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            mis_q     <= 1'b0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            mis_q     <= mis_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end

    assign P_DATA     = data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = perr_q;
    assign STP_ERR    = serr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of the receiver.
module tb_uart_rx;
    localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned t;
        logic [2:0]  f;
        logic [7:0]  d;
    } ev_t;

    ev_t         obs[$], exp_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0, n_err = 0;
    logic [7:0]  model_pd = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK)
        if (DATA_VALID | PAR_ERR | STP_ERR) obs.push_back('{cyc, {DATA_VALID, PAR_ERR, STP_ERR}, P_DATA});

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic bit_out(input logic v);
        RX_IN = v;
        repeat (OS) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic typ, input logic pbit, input logic stopb);
        logic good, mis;
        ev_t  e;
        PAR_EN  = pen;
        PAR_TYP = typ;
        mis     = pen && (pbit !== ((^d) ^ typ));
        good    = stopb && !mis;
        if (good) model_pd = d;
        e.t = cyc + (9 + int'(pen)) * OS + OS / 2 + 2 + SL;
        e.f = {good, mis, !stopb};
        e.d = model_pd;
        exp_q.push_back(e);
        bit_out(1'b0);
        PAR_EN  = ~pen;
        PAR_TYP = ~typ;
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (pen) bit_out(pbit);
        bit_out(stopb);
    endtask

    task automatic check_events(input string tag);
        chk({tag, " count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk({tag, " time"}, obs[i].t, exp_q[i].t);
            chk({tag, " flags"}, {29'd0, obs[i].f}, {29'd0, exp_q[i].f});
            chk({tag, " data"}, {24'd0, obs[i].d}, {24'd0, exp_q[i].d});
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge CLK);
        chk({tag, " P_DATA"}, {24'd0, P_DATA}, 32'd0);
        chk({tag, " DATA_VALID"}, {31'd0, DATA_VALID}, 32'd0);
        chk({tag, " PAR_ERR"}, {31'd0, PAR_ERR}, 32'd0);
        chk({tag, " STP_ERR"}, {31'd0, STP_ERR}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       pen, typ;
        repeat (3) @(posedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        idle(16);

        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(16);
        check_events("a5 nopar");

        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(12);
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(16);
        check_events("3c even");
        chk("3c hold", {24'd0, P_DATA}, 32'h3C);

        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(10);
        send(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
        RX_IN = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        idle(16);
        check_events("odd break");

        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        idle(20);
        send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(16);
        check_events("glitch");

        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(16);
        check_events("b2b");

        d = 8'h6B;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(d[i]);
        RX_IN = 1'b1;
        RST   = 1'b1;
        check_idle_outputs("mid rst");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        model_pd = 8'h00;
        idle(16);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(16);
        check_events("after rst");

        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom);
            pen = 1'($urandom);
            typ = 1'($urandom);
            send(d, pen, typ, ((^d) ^ typ) ^ ($urandom_range(3) == 0), 1'b1);
            idle($urandom_range(12));
        end
        idle(16);
        check_events("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
